cve2_instr_bus_responder: RTL

//  Responder end of the instruction fetch bus (req/gnt/rvalid/rdata/err): answers fetch

---
 rtl/cve2_instr_bus_responder.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/cve2_instr_bus_responder.sv
// ----------------------------------------------------------------------------
// cve2_instr_bus_responder
//
// Responder end of the instruction fetch bus. Accepts fetch requests from the
// IF-stage prefetch buffer, reads the addressed word from a synchronous
// word-wide memory port and returns it in order after a fixed latency. Fetches
// that are misaligned or fall outside the mapped window are answered with a
// bus error instead of touching the memory.
//
// Ports
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   stall_i            withhold grants while high
//   instr_req_i        fetch request (held with instr_addr_i until granted)
//   instr_addr_i       fetch byte address
//   instr_gnt_o        request accepted this cycle (combinational)
//   instr_rvalid_o     response valid, RspLatency cycles after its grant
//   instr_rdata_o      response data (0 unless a valid, error-free response)
//   instr_err_o        response is a bus error (qualified by rvalid)
//   mem_req_o          backing memory read strobe
//   mem_addr_o         backing memory word index
//   mem_rdata_i        backing memory data, valid the cycle after mem_req_o
//   busy_o             at least one granted request has not yet responded
// ----------------------------------------------------------------------------
module cve2_instr_bus_responder #(
  parameter logic [31:0] MemBase    = 32'h0000_0000,
  parameter int          MemSize    = 65536,
  parameter int          RspLatency = 1,
  parameter int          Depth      = 2,
  // A 4-byte window still needs a one-bit word index port.
  localparam int         MemAw      = (MemSize > 4) ? $clog2(MemSize / 4) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             stall_i,
  input  logic             instr_req_i,
  input  logic [31:0]      instr_addr_i,
  output logic             instr_gnt_o,
  output logic             instr_rvalid_o,
  output logic [31:0]      instr_rdata_o,
  output logic             instr_err_o,
  output logic             mem_req_o,
  output logic [MemAw-1:0] mem_addr_o,
  input  logic [31:0]      mem_rdata_i,
  output logic             busy_o
);

  localparam int             CntW   = $clog2(Depth + 1);
  localparam logic [CntW-1:0] DepthC = CntW'(Depth);

  // Outstanding request count.
  logic [CntW-1:0] cnt_q, cnt_d;

  // Valid/error flags of the response pipeline; index 0 is the stage loaded
  // at the end of the grant cycle, index RspLatency-1 drives the bus.
  logic [RspLatency-1:0] rsp_vld_q, rsp_vld_d;
  logic [RspLatency-1:0] rsp_err_q, rsp_err_d;

  logic [32:0]      addr_ext;
  logic [32:0]      win_lo;
  logic [32:0]      win_hi;
  logic             addr_err;
  logic [MemAw-1:0] word_idx;
  logic [31:0]      stage0_data;
  logic [31:0]      rsp_data;

  // --------------------------------------------------------------------------
  // Address decode. The window bounds are computed in 33 bits so a window
  // ending exactly at 4 GiB does not wrap to zero.
  // --------------------------------------------------------------------------
  assign addr_ext = {1'b0, instr_addr_i};
  assign win_lo   = {1'b0, MemBase};
  assign win_hi   = {1'b0, MemBase} + 33'(MemSize);
  assign addr_err = (instr_addr_i[1:0] != 2'b00) | (addr_ext < win_lo) |
                    (addr_ext >= win_hi);

  // MemBase is word aligned, so the word index only needs the in-window bits.
  assign word_idx = instr_addr_i[MemAw+1:2] - MemBase[MemAw+1:2];

  // The count compared is the registered one: a retiring response in the
  // same cycle does not open the gate for a new grant.
  assign instr_gnt_o = instr_req_i & ~stall_i & (cnt_q < DepthC);
  assign mem_req_o   = instr_gnt_o & ~addr_err;
  assign mem_addr_o  = mem_req_o ? word_idx : '0;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  // NOTE: every signal written here gets a value before any conditional or
  // loop assignment, so no path can leave it unassigned and infer a latch.
  always_comb begin
    cnt_d        = cnt_q + CntW'(instr_gnt_o) - CntW'(instr_rvalid_o);
    rsp_vld_d    = '0;
    rsp_err_d    = '0;
    rsp_vld_d[0] = instr_gnt_o;
    rsp_err_d[0] = instr_gnt_o & addr_err;
    for (int i = 1; i < RspLatency; i++) begin
      rsp_vld_d[i] = rsp_vld_q[i-1];
      rsp_err_d[i] = rsp_err_q[i-1];
    end
  end

  // NOTE: state flops use non-blocking assignments and an asynchronous
  // active-low reset, so every flop samples its old value on the same edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      rsp_vld_q <= '0;
      rsp_err_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      rsp_vld_q <= rsp_vld_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  // Memory data arrives one cycle after the grant, i.e. while the first
  // pipeline stage holds that request; errors carry zero data.
  assign stage0_data = (rsp_vld_q[0] & ~rsp_err_q[0]) ? mem_rdata_i : 32'h0;

  // --------------------------------------------------------------------------
  // Data pipeline: only needed when the response is more than one cycle late.
  // --------------------------------------------------------------------------
  if (RspLatency == 1) begin : g_rsp_data_direct
    assign rsp_data = stage0_data;
  end else begin : g_rsp_data_pipe
    logic [31:0] data_q [RspLatency-1];
    logic [31:0] data_d [RspLatency-1];

    always_comb begin
      data_d[0] = stage0_data;
      for (int i = 1; i < RspLatency - 1; i++) begin
        data_d[i] = data_q[i-1];
      end
    end

    // NOTE: the data stages are reset too (a handful of words), so the
    // pipeline contents are defined after reset rather than left as X.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int i = 0; i < RspLatency - 1; i++) begin
          data_q[i] <= '0;
        end
      end else begin
        for (int i = 0; i < RspLatency - 1; i++) begin
          data_q[i] <= data_d[i];
        end
      end
    end

    assign rsp_data = data_q[RspLatency-2];
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign instr_rvalid_o = rsp_vld_q[RspLatency-1];
  assign instr_err_o    = instr_rvalid_o & rsp_err_q[RspLatency-1];
  assign instr_rdata_o  = (instr_rvalid_o & ~rsp_err_q[RspLatency-1]) ? rsp_data : 32'h0;
  assign busy_o         = (cnt_q != '0);

  // --------------------------------------------------------------------------
  // Assertions
  // --------------------------------------------------------------------------
`ifndef SYNTHESIS
  a_params : assert property (@(posedge clk_i)
    (RspLatency >= 1) && (RspLatency <= 8) && (Depth >= 1) && (Depth <= 8) &&
    (MemSize >= 4) && ((MemSize & (MemSize - 1)) == 0) && (MemBase[1:0] == 2'b00));

  a_req_hold : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (instr_req_i && !instr_gnt_o) |=> (instr_req_i && $stable(instr_addr_i)));

  a_cnt_bound : assert property (@(posedge clk_i) disable iff (!rst_ni)
    cnt_q <= DepthC);
`endif

endmodule
